// File: rtl/i2s_pkg.sv
// Shared types and default widths for the INMP441 I2S microphone emulator.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SHIFT,
    HIZ
  } i2s_tx_state_t;

  localparam int unsigned DEF_W_SAMPLE    = 24;
  localparam int unsigned DEF_SLOT_BITS   = 32;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/i2s_pin_sync.sv
// Multi-flop synchronizer for an asynchronous pin, with one-clk rise/fall strobes
// derived from the synchronized level.
module i2s_pin_sync
  import i2s_pkg::*;
#(
  parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync[0] <= i_pin;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[STAGES-1];
    end
  end

  // Strobes are combinational so the consumer acts one edge after the level settles.
  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/inmp441_mic_i2s_emulator.sv
// I2S transmitter emulating an INMP441 microphone: slaves to external SCK/WS,
// buffers one sample from a valid/ready source and shifts it out MSB-first.
module inmp441_mic_i2s_emulator
  import i2s_pkg::*;
#(
  parameter int unsigned w_sample    = DEF_W_SAMPLE,
  parameter int unsigned slot_bits   = DEF_SLOT_BITS,
  parameter int unsigned sync_stages = DEF_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [w_sample-1:0] sample,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                lr,
  input  logic                sck,
  input  logic                ws,
  output logic                sd,
  output logic                sd_oe,
  output logic                underrun
);

  localparam int unsigned      CNT_W    = $clog2(slot_bits + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(w_sample);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(slot_bits);

  logic w_sck_level_unused;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_ws_level;
  logic w_ws_rise_unused;
  logic w_ws_fall_unused;

  i2s_pin_sync #(.STAGES(sync_stages)) u_sck_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (sck),
    .o_level (w_sck_level_unused),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  i2s_pin_sync #(.STAGES(sync_stages)) u_ws_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (ws),
    .o_level (w_ws_level),
    .o_rise  (w_ws_rise_unused),
    .o_fall  (w_ws_fall_unused)
  );

  i2s_tx_state_t       r_state;
  logic                r_ws;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [w_sample-1:0] r_hold;
  logic                r_hold_full;
  logic [w_sample-1:0] r_last;
  logic [w_sample-1:0] r_shift;
  logic                r_sd;
  logic                r_sd_oe;
  logic                r_underrun;

  logic                w_ws_change;
  logic                w_load;
  logic                w_accept;
  logic [w_sample-1:0] w_src;
  logic [CNT_W-1:0]    w_cnt_next;

  // Rise and fall of the synchronized SCK are mutually exclusive, so a WS
  // change and a load can never occur in the same clk.
  assign w_ws_change = w_sck_rise && (w_ws_level != r_ws);
  assign w_load      = (r_state == ARMED) && w_sck_fall;
  assign w_accept    = sample_valid && !r_hold_full;
  assign w_src       = r_hold_full ? r_hold : r_last;
  assign w_cnt_next  = (r_bit_cnt < CNT_SAT) ? r_bit_cnt + 1'b1 : r_bit_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ws       <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_sd       <= 1'b0;
      r_sd_oe    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_load && !r_hold_full;
      if (w_sck_rise) begin
        r_ws <= w_ws_level;
      end
      if (w_ws_change) begin
        // Any WS edge ends the current slot, complete or not.
        r_sd    <= 1'b0;
        r_sd_oe <= 1'b0;
        r_state <= (w_ws_level == lr) ? ARMED : IDLE;
      end else if (w_sck_fall) begin
        case (r_state)
          ARMED: begin
            r_shift   <= w_src << 1;
            r_sd      <= w_src[w_sample-1];
            r_sd_oe   <= 1'b1;
            r_bit_cnt <= CNT_W'(1);
            r_state   <= SHIFT;
          end
          SHIFT: begin
            r_bit_cnt <= w_cnt_next;
            if (r_bit_cnt == CNT_LAST) begin
              r_sd    <= 1'b0;
              r_sd_oe <= 1'b0;
              r_state <= HIZ;
            end else begin
              r_sd    <= r_shift[w_sample-1];
              r_shift <= r_shift << 1;
            end
          end
          HIZ: begin
            r_bit_cnt <= w_cnt_next;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // A sample offered during an underrun load still lands in holding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_last      <= '0;
    end else if (w_load && r_hold_full) begin
      r_last      <= r_hold;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= sample;
      r_hold_full <= 1'b1;
    end
  end

  assign sample_ready = !r_hold_full;
  assign sd           = r_sd;
  assign sd_oe        = r_sd_oe;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_inmp441_mic_i2s_emulator.sv
// Self-checking bench: acts as I2S master and receiver, predicting every SCK-rise
// observation from a frame-level model of the emulator.
module tb_inmp441_mic_i2s_emulator;

  localparam int W    = 24;
  localparam int SLOT = 32;
  localparam int SYNC = 2;

  logic         clk          = 1'b0;
  logic         rst_n        = 1'b0;
  logic [W-1:0] sample       = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready;
  logic         lr           = 1'b0;
  logic         sck          = 1'b1;
  logic         ws           = 1'b0;
  logic         sd;
  logic         sd_oe;
  logic         underrun;

  inmp441_mic_i2s_emulator #(
    .w_sample    (W),
    .slot_bits   (SLOT),
    .sync_stages (SYNC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .lr           (lr),
    .sck          (sck),
    .ws           (ws),
    .sd           (sd),
    .sd_oe        (sd_oe),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic [W-1:0] acc_q[$];
  logic [W-1:0] rx_log[$];
  logic [W-1:0] m_last      = '0;
  logic         m_ws_r      = 1'b0;
  int           m_underruns = 0;
  int           seen_ur     = 0;
  int           acc_total   = 0;
  int           rise_idx    = 0;
  int           own_start   = 0;
  int           own_limit   = 0;
  bit           own_valid   = 0;
  logic [W-1:0] own_word    = '0;
  logic [W-1:0] rx_word     = '0;
  bit           feeder_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] last_rx();
    if (rx_log.size() == 0) return 'x;
    return 32'(rx_log[rx_log.size()-1]);
  endfunction

  always @(posedge clk) begin
    if (rst_n && sample_valid && sample_ready) begin
      acc_q.push_back(sample);
      acc_total++;
    end
  end

  always @(negedge clk) begin
    if (underrun) seen_ur++;
  end

  task automatic model_reset();
    acc_q.delete();
    m_last    = '0;
    m_ws_r    = 1'b0;
    own_valid = 0;
  endtask

  task automatic push(input logic [W-1:0] v);
    int guard = 0;
    @(negedge clk);
    sample       = v;
    sample_valid = 1'b1;
    while (!sample_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("push_ready", sample_ready, 1);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // One WS half-frame of l SCK periods (half-period h clk cycles).
  task automatic run_half(input logic ws_val, input int l, input int h, input int reset_at);
    for (int j = 0; j < l; j++) begin
      bit  chg;
      bit  exp_oe;
      int  k;
      time t0;
      chg = 0;
      sck = 1'b0;
      if (j == 0) ws = ws_val;
      #(h * 10);
      sck = 1'b1;
      t0  = $time;
      rise_idx++;
      if (j == 0) begin
        chg    = (ws_val != m_ws_r);
        m_ws_r = ws_val;
        if (chg && ws_val == lr) begin
          own_valid = 1;
          own_start = rise_idx;
          own_limit = (l < W) ? l : W;
          rx_word   = '0;
        end
      end
      k      = rise_idx - own_start;
      exp_oe = own_valid && k >= 1 && k <= own_limit;
      if (exp_oe && k == 1) begin
        if (acc_q.size() > 0) begin
          own_word = acc_q.pop_front();
          m_last   = own_word;
        end else begin
          own_word = m_last;
          m_underruns++;
        end
      end
      check("sd_oe", sd_oe, exp_oe);
      if (exp_oe) begin
        check("sd", sd, own_word[W-k]);
        rx_word = {rx_word[W-2:0], sd};
        if (k == own_limit) rx_log.push_back(rx_word);
      end
      check("sample_ready", sample_ready, acc_q.size() == 0);
      if (j == 0 && chg && ws_val != lr) begin
        #40;
        check("oe_drop", sd_oe, 0);
      end
      if (j == reset_at) begin
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_sd_oe", sd_oe, 0);
        check("rst_sd", sd, 0);
        check("rst_ready", sample_ready, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      #(h * 10 - ($time - t0));
    end
  endtask

  task automatic run_own_frame(input int l_own, input int reset_at);
    int h;
    h = $urandom_range(5, 8);
    if (ws == lr) run_half(!lr, $urandom_range(25, 32), h, -1);
    run_half(lr, l_own, h, reset_at);
    run_half(!lr, $urandom_range(25, 32), h, -1);
  endtask

  task automatic feeder();
    int base;
    int v;
    int guard;
    v     = 1;
    guard = 0;
    @(negedge clk);
    sample       = W'(v);
    sample_valid = 1'b1;
    base         = acc_total;
    while (v <= 3 && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (acc_total != base) begin
        base = acc_total;
        v++;
        if (v <= 3) sample = W'(v);
        else sample_valid = 1'b0;
      end
    end
    sample_valid = 1'b0;
    check("bp_accepts", v, 4);
    feeder_done = 1;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int u0;
    repeat (3) @(negedge clk);
    check("reset_sd", sd, 0);
    check("reset_sd_oe", sd_oe, 0);
    check("reset_ready", sample_ready, 1);
    check("reset_underrun", underrun, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic left slot
    lr = 1'b0;
    push(24'hA5C30F);
    run_own_frame($urandom_range(25, 32), -1);
    check("basic_rx", last_rx(), 24'hA5C30F);
    check("basic_no_underrun", seen_ur, 0);

    // Right channel
    lr = 1'b1;
    push(24'hA5C30F);
    run_own_frame($urandom_range(25, 32), -1);
    check("right_rx", last_rx(), 24'hA5C30F);

    // Underrun: second frame repeats the last sample with one pulse
    lr = 1'b0;
    u0 = seen_ur;
    push(24'h000001);
    run_own_frame(32, -1);
    check("ur_rx1", last_rx(), 24'h000001);
    check("ur_pulses_f1", seen_ur - u0, 0);
    run_own_frame(32, -1);
    check("ur_rx2", last_rx(), 24'h000001);
    check("ur_pulses_f2", seen_ur - u0, 1);

    // Back-pressure: valid held high, values 1,2,3
    u0          = seen_ur;
    feeder_done = 0;
    fork
      feeder();
    join_none
    for (int f = 0; f < 3; f++) run_own_frame($urandom_range(25, 32), -1);
    for (int i = 0; i < 1000 && !feeder_done; i++) @(negedge clk);
    check("bp_feeder_done", feeder_done, 1);
    check("bp_rx1", 32'(rx_log[rx_log.size()-3]), 1);
    check("bp_rx2", 32'(rx_log[rx_log.size()-2]), 2);
    check("bp_rx3", last_rx(), 3);
    check("bp_no_underrun", seen_ur - u0, 0);

    // Short slot: WS toggles after 10 bits; next slot uses the next sample
    push(24'hABCDEF);
    run_own_frame(10, -1);
    check("short_rx10", last_rx(), 32'h2AF);
    push(24'h123456);
    run_own_frame(32, -1);
    check("short_next_rx", last_rx(), 24'h123456);

    // Overrun: own half longer than slot_bits
    push(24'h0F0F0F);
    run_own_frame(40, -1);
    check("overrun_rx", last_rx(), 24'h0F0F0F);

    // Reset mid-slot at bit 12 with a second sample waiting in holding
    push(24'h111111);
    fork
      push(24'h222222);
    join_none
    run_own_frame(32, 12);
    push(24'h333333);
    run_own_frame(32, -1);
    check("rst_next_rx", last_rx(), 24'h333333);

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 3) != 0) push(W'($urandom));
      if ($urandom_range(0, 1) == 1 && ws != lr) lr = ~lr;
      run_own_frame($urandom_range(20, 36), -1);
    end

    check("underrun_total", seen_ur, m_underruns);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
